ttt_board_ctrl: RTL
===================

Name: ttt_board_ctrl

Overview:
- Writer side of the 5x5 board interface: owns the 25 two-bit cell registers that win_declarer reads.
- Accepts player moves over a valid/ready handshake and rejects illegal ones.
- Alternates turns, samples win_declarer's playerwin/player2win one cycle after each write, and latches the game result (P1 win, P2 win or draw).

Parameters:
- P1_CODE, 2'd3, cell code written for player 1.
- P2_CODE, 2'd2, cell code written for player 2.
- EMPTY_CODE, 2'd0, cell code for an empty cell.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- new_game  input  1  synchronous clear of board and game state.
- move_valid  input  1  move request present.
- move_idx  input  5  target cell 0..24 (0 maps to board1, 24 to board25).
- move_ready  output  1  controller can accept a move this cycle.
- move_err  output  1  one-cycle pulse when an accepted request is illegal.
- playerwin  input  1  from win_declarer; player 1 has a line.
- player2win  input  1  from win_declarer; player 2 has a line.
- board1..board25  output  2 each  registered cell states, wired to win_declarer.
- turn  output  1  0 = player 1 to move, 1 = player 2 to move.
- game_over  output  1  high once a result is latched.
- winner  output  2  00 none, 01 P1, 10 P2, 11 draw.

Behaviour:
- Reset (rst_n low, asynchronous):
  - all board cells = EMPTY_CODE
  - turn=0, game_over=0, winner=00, move_err=0
  - move count=0, state=PLAY
  - move_ready=1 once rst_n deasserts.
- States:
  - PLAY: move_ready=1.
  - CHECK: move_ready=0; lasts exactly one cycle.
  - DONE: move_ready=0; holds until new_game.
- Handshake: a transfer occurs when move_valid && move_ready at a rising edge. A request not accepted must be held by the source.
- Legal move (move_idx<=24, cell==EMPTY_CODE):
  - At edge N, write P1_CODE (turn=0) or P2_CODE (turn=1) to the cell, increment the 5-bit move count, and enter CHECK.
  - The cell value is visible on boardX in cycle N+1.
- Illegal move (move_idx>24 or cell occupied):
  - The request is consumed.
  - move_err=1 for the cycle after edge N.
  - Board, turn and count are unchanged; state stays PLAY.
- CHECK (cycle N+1): playerwin and player2win are combinational from the board registers and are sampled at edge N+1.
  - If the mover's flag is set: winner = 01 or 10 for the mover, game_over=1, go to DONE.
  - If both flags are high, the mover takes priority.
  - Else if the non-mover's flag alone is set: that player wins, go to DONE (defensive case only).
  - Else if count==25: winner=11, game_over=1, go to DONE.
  - Else toggle turn and return to PLAY.
- Latency: accept-to-result is 1 cycle; accept-to-next-ready is 2 cycles.
- DONE: move_valid is ignored and move_err is never raised; all outputs hold.
- new_game: in any state, a synchronous clear to reset values at the next edge.
  - It takes priority over a simultaneous move, which is dropped and raises no move_err.
  - Asserted during CHECK, it discards the pending result.
- Reset mid-game: immediate asynchronous clear; no partial result is retained.
- move_err and a cell write never occur in the same cycle.

Test Plan:
- Reset, then P1 moves 4, 9, 14, 19, 24 while P2 moves 0, 1, 2, 3 → board5/10/15/20/25 = 3; winner=01 and game_over=1 one cycle after the 9th accept; turn=0 on entering DONE.
- Mirror of the first case, with P2 filling indices 4, 9, 14, 19, 24 → those cells = 2; winner=10.
- P1 moves 7, then P2 requests 7 → move_err high one cycle, board8 stays 3, turn stays 1; P2 then requests 31 → move_err again, no write.
- Fill all 25 cells in a no-line pattern → winner=11 after the 25th accept, game_over=1; a further move_valid gives move_ready=0 and no move_err.
- Mid-game, new_game together with move_valid → all cells 0, turn=0, count=0, no write, no move_err; a following move to 12 gives board13=3.
- Drop rst_n asynchronously mid-CHECK → outputs clear before the next edge, winner=00, move_ready=1 after release.

Source files
------------

// File: rtl/ttt_board_ctrl.sv
// Move controller for the 5x5 board. It owns the cell registers that win_declarer reads,
// checks that each move is legal, alternates turns and latches the game result.
module ttt_board_ctrl #(
  parameter logic [1:0] P1_CODE    = 2'd3,
  parameter logic [1:0] P2_CODE    = 2'd2,
  parameter logic [1:0] EMPTY_CODE = 2'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       new_game,
  input  logic       move_valid,
  input  logic [4:0] move_idx,
  output logic       move_ready,
  output logic       move_err,
  input  logic       playerwin,
  input  logic       player2win,
  output logic [1:0] board1,
  output logic [1:0] board2,
  output logic [1:0] board3,
  output logic [1:0] board4,
  output logic [1:0] board5,
  output logic [1:0] board6,
  output logic [1:0] board7,
  output logic [1:0] board8,
  output logic [1:0] board9,
  output logic [1:0] board10,
  output logic [1:0] board11,
  output logic [1:0] board12,
  output logic [1:0] board13,
  output logic [1:0] board14,
  output logic [1:0] board15,
  output logic [1:0] board16,
  output logic [1:0] board17,
  output logic [1:0] board18,
  output logic [1:0] board19,
  output logic [1:0] board20,
  output logic [1:0] board21,
  output logic [1:0] board22,
  output logic [1:0] board23,
  output logic [1:0] board24,
  output logic [1:0] board25,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner
);

  typedef enum logic [1:0] {PLAY, CHECK, DONE} state_t;

  state_t     state, state_n;
  logic [1:0] cells   [25];
  logic [1:0] cells_n [25];
  logic [4:0] count, count_n;
  logic       turn_n, game_over_n, move_err_n;
  logic [1:0] winner_n;
  logic [1:0] target;
  logic       legal, mover_win, other_win;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PLAY;
      count     <= '0;
      turn      <= 1'b0;
      game_over <= 1'b0;
      winner    <= '0;
      move_err  <= 1'b0;
      for (int unsigned i = 0; i < 25; i++) cells[i] <= EMPTY_CODE;
    end else begin
      state     <= state_n;
      count     <= count_n;
      turn      <= turn_n;
      game_over <= game_over_n;
      winner    <= winner_n;
      move_err  <= move_err_n;
      for (int unsigned i = 0; i < 25; i++) cells[i] <= cells_n[i];
    end
  end

  // Contents of the requested cell; out-of-range indices read as empty and are rejected by legal.
  always_comb begin
    target = EMPTY_CODE;
    for (int unsigned i = 0; i < 25; i++)
      if (move_idx == i[4:0]) target = cells[i];
  end

  assign legal      = (move_idx <= 5'd24) && (target == EMPTY_CODE);
  assign mover_win  = turn ? player2win : playerwin;
  assign other_win  = turn ? playerwin : player2win;
  assign move_ready = (state == PLAY);

  always_comb begin
    state_n     = state;
    count_n     = count;
    turn_n      = turn;
    game_over_n = game_over;
    winner_n    = winner;
    move_err_n  = 1'b0;
    for (int unsigned i = 0; i < 25; i++) cells_n[i] = cells[i];

    if (new_game) begin
      state_n     = PLAY;
      count_n     = '0;
      turn_n      = 1'b0;
      game_over_n = 1'b0;
      winner_n    = '0;
      for (int unsigned i = 0; i < 25; i++) cells_n[i] = EMPTY_CODE;
    end else begin
      unique case (state)
        PLAY: begin
          if (move_valid) begin
            if (legal) begin
              for (int unsigned i = 0; i < 25; i++)
                if (move_idx == i[4:0]) cells_n[i] = turn ? P2_CODE : P1_CODE;
              count_n = count + 5'd1;
              state_n = CHECK;
            end else begin
              move_err_n = 1'b1;
            end
          end
        end
        CHECK: begin
          if (mover_win) begin
            winner_n    = turn ? 2'b10 : 2'b01;
            game_over_n = 1'b1;
            state_n     = DONE;
          end else if (other_win) begin
            winner_n    = turn ? 2'b01 : 2'b10;
            game_over_n = 1'b1;
            state_n     = DONE;
          end else if (count == 5'd25) begin
            winner_n    = 2'b11;
            game_over_n = 1'b1;
            state_n     = DONE;
          end else begin
            turn_n  = ~turn;
            state_n = PLAY;
          end
        end
        DONE:    state_n = DONE;
        default: state_n = PLAY;
      endcase
    end
  end

  assign board1  = cells[0];
  assign board2  = cells[1];
  assign board3  = cells[2];
  assign board4  = cells[3];
  assign board5  = cells[4];
  assign board6  = cells[5];
  assign board7  = cells[6];
  assign board8  = cells[7];
  assign board9  = cells[8];
  assign board10 = cells[9];
  assign board11 = cells[10];
  assign board12 = cells[11];
  assign board13 = cells[12];
  assign board14 = cells[13];
  assign board15 = cells[14];
  assign board16 = cells[15];
  assign board17 = cells[16];
  assign board18 = cells[17];
  assign board19 = cells[18];
  assign board20 = cells[19];
  assign board21 = cells[20];
  assign board22 = cells[21];
  assign board23 = cells[22];
  assign board24 = cells[23];
  assign board25 = cells[24];

endmodule
